// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master blocks.
//   i2c_ctrl_state_t : transaction controller states
//   I2C_ACK/I2C_NACK : value of the ninth (acknowledge) bit on the bus
//   SS_START/SS_STOP : start_stop_generator condition select
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;
  localparam logic SS_START = 1'b1;
  localparam logic SS_STOP  = 1'b0;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StWrWait,
    StWrXfer,
    StRdXfer,
    StStop,
    StDone
  } i2c_ctrl_state_t;

endpackage

// File: rtl/i2c_watchdog.sv
// Cycle watchdog for the I2C transaction controller.
//   clk, rst_  : system clock, synchronous active-low reset
//   clear      : reload the counter with zero (takes priority)
//   count_en   : advance the counter this cycle
//   expired    : count has reached TIMEOUT_CYC-1 while counting is enabled
module i2c_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst_,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CntW-1:0] cnt_q;

  assign expired = count_en && (cnt_q == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en && !expired) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Transaction-level I2C master controller. Sequences START, address byte, data bytes and
// STOP through start_stop_generator and the byte transceiver, with ACK/NACK status and a
// watchdog on every hardware wait state.
//   cmd_*               : host command handshake (addr, rw, len; len 0 = address probe)
//   wr_* / rd_*         : write-byte handshake, received-byte strobe
//   busy, done          : transaction in flight / 1-cycle end pulse
//   nack_err, timeout_err : status, qualified by done
//   ss_*                : start_stop_generator control
//   byte_*              : byte transceiver control and status
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned LEN_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic                  cmd_rw,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [7:0]            wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [7:0]            rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  nack_err,
  output logic                  timeout_err,
  output logic                  ss_enable,
  output logic                  ss_start_stop,
  input  logic                  ss_ending,
  output logic                  byte_go,
  output logic [7:0]            byte_tx,
  output logic                  byte_rd,
  output logic                  byte_ack_out,
  input  logic                  byte_done,
  input  logic [7:0]            byte_rx,
  input  logic                  byte_ack_in
);

  i2c_ctrl_state_t state_q, state_d;
  logic                  rw_q, rw_d;
  logic [LEN_W-1:0]      rem_q, rem_d, rem_dec;
  logic [7:0]            tx_q, tx_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  go_q, go_d;
  logic                  nack_q, nack_d;
  logic                  tout_q, tout_d;
  logic                  wd_clear, wd_count_en, wd_expired;

  // Saturating decrement: remaining never wraps below zero.
  assign rem_dec = (rem_q != '0) ? rem_q - LEN_W'(1) : rem_q;

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    rem_d       = rem_q;
    tx_d        = tx_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    go_d        = 1'b0;
    nack_d      = nack_q;
    tout_d      = tout_q;
    wd_count_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          rw_d    = cmd_rw;
          rem_d   = cmd_len;
          tx_d    = {cmd_addr, cmd_rw};
          nack_d  = 1'b0;
          tout_d  = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        wd_count_en = 1'b1;
        if (ss_ending) begin
          go_d    = 1'b1;
          state_d = StAddr;
        end
      end
      StAddr: begin
        wd_count_en = 1'b1;
        if (byte_done) begin
          if (byte_ack_in == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else if (rem_q == '0) begin
            state_d = StStop;
          end else if (rw_q) begin
            go_d    = 1'b1;
            state_d = StRdXfer;
          end else begin
            state_d = StWrWait;
          end
        end
      end
      StWrWait: begin
        if (wr_valid) begin
          tx_d    = wr_data;
          go_d    = 1'b1;
          state_d = StWrXfer;
        end
      end
      StWrXfer: begin
        wd_count_en = 1'b1;
        if (byte_done) begin
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            // A NACK on the final byte is how a slave may end a write.
            state_d = StStop;
          end else if (byte_ack_in == I2C_NACK) begin
            nack_d  = 1'b1;
            state_d = StStop;
          end else begin
            state_d = StWrWait;
          end
        end
      end
      StRdXfer: begin
        wd_count_en = 1'b1;
        if (byte_done) begin
          rd_data_d  = byte_rx;
          rd_valid_d = 1'b1;
          rem_d      = rem_dec;
          if (rem_dec == '0) begin
            state_d = StStop;
          end else begin
            go_d = 1'b1;
          end
        end
      end
      StStop: begin
        wd_count_en = 1'b1;
        if (ss_ending) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Watchdog abort skips STOP entirely; the bus is left to the generator's own release.
    if (wd_expired) begin
      tout_d     = 1'b1;
      go_d       = 1'b0;
      rd_valid_d = 1'b0;
      state_d    = StDone;
    end
  end

  // Each read-byte re-entry restarts the watchdog just like a state change.
  assign wd_clear = (state_d != state_q) || go_d;

  i2c_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst_    (rst_),
    .clear   (wd_clear),
    .count_en(wd_count_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= StIdle;
      rw_q       <= 1'b0;
      rem_q      <= '0;
      tx_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      go_q       <= 1'b0;
      nack_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      rem_q      <= rem_d;
      tx_q       <= tx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      go_q       <= go_d;
      nack_q     <= nack_d;
      tout_q     <= tout_d;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign nack_err      = done && nack_q;
  assign timeout_err   = done && tout_q;
  assign wr_ready      = (state_q == StWrWait);
  assign rd_data       = rd_data_q;
  assign rd_valid      = rd_valid_q;
  assign ss_enable     = ((state_q == StStart) || (state_q == StStop)) && !wd_expired;
  assign ss_start_stop = (state_q == StStart) ? SS_START : SS_STOP;
  assign byte_go       = go_q;
  assign byte_tx       = tx_q;
  assign byte_rd       = (state_q == StRdXfer);
  assign byte_ack_out  = (byte_rd && (rem_q == LEN_W'(1))) ? I2C_NACK : I2C_ACK;

endmodule

// File: doc/i2c_master_ctrl.md
# i2c_master_ctrl

Transaction-level controller for the I2C master. It accepts a host command (7-bit address, direction, byte count) and sequences `start_stop_generator` and the byte transceiver through START, the address byte, data bytes and STOP. It also collects ACK/NACK status and enforces a watchdog timeout. It sits between the host register interface and the bit-level I2C blocks, running on the 50 MHz system clock.

## Interface
- `LEN_W`, 4: width of `cmd_len`; max transfer is 2^LEN_W-1 bytes.
- `TIMEOUT_CYC`, 50000: cycles allowed in any wait state before abort.
- `clk`  in  1  system clock, single clock domain.
- `rst_`  in  1  reset, synchronous, active-low.
- `cmd_valid` / `cmd_ready`  in/out  1/1  command handshake; transfer when both high.
- `cmd_addr`  in  7  slave address.
- `cmd_rw`  in  1  direction: 1 = read, 0 = write.
- `cmd_len`  in  LEN_W  data byte count; 0 = address-only probe.
- `wr_data` / `wr_valid` / `wr_ready`  in/in/out  8/1/1  write-byte handshake.
- `rd_data` / `rd_valid`  out/out  8/1  received byte plus 1-cycle strobe; no backpressure.
- `busy`  out  1  high from command accept through DONE.
- `done`  out  1  1-cycle pulse at transaction end.
- `nack_err`, `timeout_err`  out  1  status, valid only while `done` is high.
- `ss_enable`, `ss_start_stop`  out  1  drive `start_stop_generator`; `ss_start_stop` 1 = START, 0 = STOP.
- `ss_ending`  in  1  generator finished its condition.
- `byte_go`  out  1  1-cycle pulse that starts one byte transfer.
- `byte_tx`  out  8  byte to transmit.
- `byte_rd`  out  1  1 = receive byte.
- `byte_ack_out`  out  1  ACK bit the master sends after a received byte (1 = NACK).
- `byte_done`  in  1  transceiver finished the byte.
- `byte_rx`  in  8  received byte.
- `byte_ack_in`  in  1  slave ACK bit (0 = ACK).

## Operation
- States: IDLE, START, ADDR, WR_WAIT, WR_XFER, RD_XFER, STOP, DONE.
- IDLE:
  - `cmd_ready`=1.
  - On handshake: latch addr/rw/len and set `remaining`=len → START.
- START: `ss_enable`=1, `ss_start_stop`=1, both held until `ss_ending` → ADDR.
- ADDR:
  - On entry, pulse `byte_go` with `byte_tx`={addr,rw} and `byte_rd`=0.
  - On `byte_done`:
    - `byte_ack_in`=1 → set nack flag → STOP.
    - Otherwise, `remaining`==0 → STOP.
    - Otherwise, rw → RD_XFER; else → WR_WAIT.
- WR_WAIT: `wr_ready`=1; on `wr_valid` latch the byte into `byte_tx` → WR_XFER.
- WR_XFER:
  - On entry, pulse `byte_go`.
  - On `byte_done`, decrement `remaining`.
  - NACK with bytes still remaining → nack flag, STOP.
  - NACK on the last byte is normal completion.
  - Next: `remaining`==0 → STOP; else → WR_WAIT.
- RD_XFER:
  - On entry, pulse `byte_go` with `byte_rd`=1 and `byte_ack_out`=(`remaining`==1).
  - On `byte_done`: `rd_data`←`byte_rx`, `rd_valid` pulses, decrement `remaining`.
  - Then re-enter RD_XFER, or go to STOP when `remaining` reaches 0.
- STOP: `ss_enable`=1, `ss_start_stop`=0 until `ss_ending` → DONE.
- DONE: `done`=1 with the status flags → IDLE. Flags clear on the next command accept.
- Timeout:
  - A watchdog counter clears on every state change and counts in START, ADDR, WR_XFER, RD_XFER and STOP. WR_WAIT waits on the host and is not timed.
  - When the count reaches `TIMEOUT_CYC`-1: `timeout_err` set, `ss_enable` dropped, → DONE directly (no STOP).
- `cmd_valid` while busy is ignored.
- `byte_done` or `ss_ending` arriving in a state that does not expect it is ignored.

## Timing
- Reset values: state IDLE; `cmd_ready`=1; all other outputs 0; counters 0.
- Reset mid-transaction aborts on the next edge. `ss_enable` falls, which releases the generator.
- Command accepted at edge N → `ss_enable`=1 from N+1.
- `ss_ending` at edge M → `byte_go` at M+1.
- `byte_done` at edge K:
  - next `byte_go` (read) at K+1;
  - `wr_ready` at K+1 (write);
  - `rd_valid` at K+1.
- Last `byte_done` → `ss_enable`/STOP at K+1. `ss_ending` at edge S → `done` at S+1, `busy` low and `cmd_ready` high at S+2.
- `remaining` is LEN_W bits and never decrements below 0.

## Structure
- Package `i2c_pkg`:
  - state enum `i2c_ctrl_state_t`;
  - constants `I2C_ACK`=0, `I2C_NACK`=1, `SS_START`=1, `SS_STOP`=0;
  - `I2C_ADDR_W`=7.
- Sub-module `i2c_watchdog`: loadable cycle counter with `clear`, `count_en` and `expired`, parameterised by `TIMEOUT_CYC`.

## Test plan
- Write 2 bytes 0xA5, 0x3C to addr 0x50, all ACK → `byte_tx` sequence 0xA0, 0xA5, 0x3C; STOP; `done` with no errors.
- Read 3 bytes from 0x3C, rx 0x11/0x22/0x33 → `byte_tx`=0x79; `byte_ack_out` 0, 0, 1; three `rd_valid` strobes in order.
- Address NACK on write of 4 bytes to 0x27 → no `wr_ready`; STOP; `done` with `nack_err`=1.
- Probe with len=0 to 0x68, ACK → START, addr 0xD0, STOP, `done` with clean status.
- `ss_ending` held low with `TIMEOUT_CYC`=100 → `timeout_err`+`done` exactly 100 cycles after START entry; `ss_enable`=0.
- `rst_` low during WR_XFER → next edge IDLE, `ss_enable`=0, `busy`=0; a fresh command then completes normally.
